// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-channel memory arbiter/controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam int RESP_ERR_DATA = 0;

    // Channel index width; a single channel still needs one bit to hold index 0.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer with wrap, and moves
// the pointer past the winner only when the grant is actually accepted.
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
            idx = (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Multi-channel memory controller: round-robin accept, one single-beat DDR
// transaction at a time, per-channel one-hot response with read timeout.
module mem_arb_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    // Handshake: a request transfers on the rising edge where req_valid[i] and
    // req_ready[i] are both high; masters hold we/addr/wdata stable until then.
    input  logic [NUM_CH-1:0]              req_valid,
    output logic [NUM_CH-1:0]              req_ready,
    input  logic [NUM_CH-1:0]              req_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]              rsp_valid,
    output logic                           rsp_err,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           ddr_wr_req,
    output logic                           ddr_rd_req,
    output logic [ADDR_WIDTH-1:0]          ddr_addr,
    output logic [DATA_WIDTH-1:0]          ddr_wr_data,
    input  logic [DATA_WIDTH-1:0]          ddr_rd_data,
    input  logic                           ddr_rd_valid
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(RD_TIMEOUT);

    state_e                state, state_nxt;
    logic [NUM_CH-1:0]     grant;
    logic [CH_W-1:0]       grant_idx;
    logic                  accept;
    logic                  timeout;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic [CH_W-1:0]       ch_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is withheld during reset so nothing can transfer on a reset edge.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;
    assign accept    = (state == IDLE) && !reset && (|grant);
    assign timeout   = (cnt_q == CNT_W'(RD_TIMEOUT - 1));

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? RESP : RD_WAIT;
            RD_WAIT: if (ddr_rd_valid || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ch_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch_q    <= grant_idx;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        err_q   <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                ISSUE: cnt_q <= '0;
                RD_WAIT: begin
                    // Data on the terminal-count cycle still counts as a good read.
                    if (ddr_rd_valid) begin
                        rdata_q <= ddr_rd_data;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= DATA_WIDTH'(RESP_ERR_DATA);
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ddr_wr_req  = (state == ISSUE) && we_q;
    assign ddr_rd_req  = (state == ISSUE) && !we_q;
    assign ddr_addr    = (state == ISSUE) ? addr_q : '0;
    assign ddr_wr_data = (state == ISSUE) ? wdata_q : '0;

    assign rsp_valid = (state == RESP) ? (NUM_CH'(1) << ch_q) : '0;
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_data  = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: queued masters, a latency-programmable DDR device,
// and a transaction-level reference model predicting grants and responses.
module tb_mem_arb_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int TO  = 16;
    localparam int EW  = 32 + 8 + 1 + DW;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    rsp_valid;
    logic              rsp_err;
    logic [DW-1:0]     rsp_data;
    logic              ddr_wr_req;
    logic              ddr_rd_req;
    logic [AW-1:0]     ddr_addr;
    logic [DW-1:0]     ddr_wr_data;
    logic [DW-1:0]     ddr_rd_data;
    logic              ddr_rd_valid;

    mem_arb_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .RD_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .ddr_wr_req   (ddr_wr_req),
        .ddr_rd_req   (ddr_rd_req),
        .ddr_addr     (ddr_addr),
        .ddr_wr_data  (ddr_wr_data),
        .ddr_rd_data  (ddr_rd_data),
        .ddr_rd_valid (ddr_rd_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- state ----------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [5:0]    lat;   // device read latency in cycles, 0 = never answers
    } req_t;

    typedef struct {
        int          cyc;
        int          ch;
        logic        err;
        logic [DW-1:0] data;
    } rsp_rec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    req_t          req_q[NCH][$];
    bit            pop_pend[NCH];
    logic [EW-1:0] exp_q[$];
    rsp_rec_t      rsp_log[$];
    int            grant_log[$];
    int            acc_cyc_log[$];

    logic [DW-1:0] ref_mem[1024];
    logic [DW-1:0] dev_mem[1024];

    int            m_ptr  = 0;
    bit            m_busy = 0;

    bit            dx_valid = 0;
    logic          dx_we;
    logic [AW-1:0] dx_addr;
    logic [DW-1:0] dx_data;

    int            dcnt    = 0;
    int            cur_lat = 0;
    logic [AW-1:0] daddr   = '0;
    bit            stray   = 0;

    // ---------------- driver / monitor ----------------
    task automatic push_req(input int ch, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int lat);
        req_t r;
        r.we   = we;
        r.addr = addr;
        r.data = data;
        r.lat  = 6'(lat);
        req_q[ch].push_back(r);
    endtask

    task automatic step(input bit rst);
        logic [NCH-1:0] exp_ready;
        logic [NCH-1:0] oh;
        logic [EW-1:0]  e;
        int             g;
        int             c;
        req_t           h;
        rsp_rec_t       rec;

        @(negedge clk);
        cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (pop_pend[i]) begin
                void'(req_q[i].pop_front());
                pop_pend[i] = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (req_q[i].size() > 0) begin
                h = req_q[i][0];
                req_valid[i]            = 1'b1;
                req_we[i]               = h.we;
                req_addr[i*AW +: AW]    = h.addr;
                req_wdata[i*DW +: DW]   = h.data;
            end else begin
                req_valid[i]            = 1'b0;
                req_we[i]               = 1'b0;
                req_addr[i*AW +: AW]    = '0;
                req_wdata[i*DW +: DW]   = '0;
            end
        end
        reset        = rst;
        ddr_rd_valid = 1'b0;
        ddr_rd_data  = '0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                ddr_rd_valid = 1'b1;
                ddr_rd_data  = dev_mem[daddr];
            end
        end
        if (stray) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data  = $urandom;
            stray        = 0;
        end
        #1;

        // grant prediction from the round-robin rule
        exp_ready = '0;
        g = -1;
        if (!rst && !m_busy) begin
            for (int k = 0; k < NCH; k++) begin
                c = (m_ptr + k) % NCH;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        n_vec++;
        if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
        end

        // DDR side: exactly one strobe, on the cycle after an accept
        n_vec++;
        if (dx_valid) begin
            if (ddr_wr_req !== dx_we || ddr_rd_req !== !dx_we || ddr_addr !== dx_addr ||
                (dx_we && ddr_wr_data !== dx_data)) begin
                n_err++;
                $display("FAIL ddr_issue cyc=%0d got wr=%b rd=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                         cyc, ddr_wr_req, ddr_rd_req, ddr_addr, ddr_wr_data, dx_we, dx_addr, dx_data);
            end
            dx_valid = 0;
        end else if (ddr_wr_req !== 1'b0 || ddr_rd_req !== 1'b0 || ddr_addr !== '0 || ddr_wr_data !== '0) begin
            n_err++;
            $display("FAIL ddr_idle cyc=%0d got wr=%b rd=%b addr=%h wdata=%h exp all 0",
                     cyc, ddr_wr_req, ddr_rd_req, ddr_addr, ddr_wr_data);
        end
        if (ddr_wr_req === 1'b1) dev_mem[ddr_addr] = ddr_wr_data;
        if (ddr_rd_req === 1'b1) begin
            daddr = ddr_addr;
            dcnt  = cur_lat;
        end

        // response side
        if (rsp_valid !== '0) begin
            rec.cyc = cyc;
            rec.ch  = -1;
            for (int i = NCH - 1; i >= 0; i--) if (rsp_valid[i] === 1'b1) rec.ch = i;
            rec.err  = rsp_err;
            rec.data = rsp_data;
            rsp_log.push_back(rec);
        end
        n_vec++;
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e[DW+8 -: 8]] = 1'b1;
            if (rsp_valid !== oh || rsp_err !== e[DW] || rsp_data !== e[DW-1:0]) begin
                n_err++;
                $display("FAIL rsp cyc=%0d got valid=%b err=%b data=%h exp valid=%b err=%b data=%h",
                         cyc, rsp_valid, rsp_err, rsp_data, oh, e[DW], e[DW-1:0]);
            end
            m_busy = 0;
        end else if (rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_data !== '0) begin
            n_err++;
            $display("FAIL rsp_quiet cyc=%0d got valid=%b err=%b data=%h exp all 0",
                     cyc, rsp_valid, rsp_err, rsp_data);
        end

        // accept: model computes what the response must be and when
        if (g >= 0) begin
            h = req_q[g][0];
            pop_pend[g] = 1;
            grant_log.push_back(g);
            acc_cyc_log.push_back(cyc);
            m_ptr    = (g + 1) % NCH;
            m_busy   = 1;
            dx_valid = 1;
            dx_we    = h.we;
            dx_addr  = h.addr;
            dx_data  = h.data;
            cur_lat  = int'(h.lat);
            if (h.we) begin
                ref_mem[h.addr] = h.data;
                exp_q.push_back({32'(cyc + 2), 8'(g), 1'b0, {DW{1'b0}}});
            end else if (h.lat != 0 && int'(h.lat) <= TO) begin
                exp_q.push_back({32'(cyc + 2 + int'(h.lat)), 8'(g), 1'b0, ref_mem[h.addr]});
            end else begin
                exp_q.push_back({32'(cyc + 2 + TO), 8'(g), 1'b1, {DW{1'b0}}});
            end
        end

        if (rst) begin
            exp_q.delete();
            m_busy   = 0;
            m_ptr    = 0;
            dx_valid = 0;
            dcnt     = 0;
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((req_q[0].size() + req_q[1].size() + req_q[2].size() > 0 ||
                exp_q.size() > 0 || m_busy) && n < bound) begin
            step(0);
            n++;
        end
        n_vec++;
        if (n >= bound) begin
            n_err++;
            $display("FAIL drain_timeout cycles=%0d outstanding=%0d required 0", n, exp_q.size());
        end
        step(0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset        = 1'b1;
        req_valid    = '0;
        req_we       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        ddr_rd_data  = '0;
        ddr_rd_valid = 1'b0;
        repeat (3) @(negedge clk);
        req_valid[0] = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_data !== '0 ||
            ddr_wr_req !== 1'b0 || ddr_rd_req !== 1'b0 || ddr_addr !== '0 || ddr_wr_data !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got ready=%b rsp=%b err=%b data=%h wr=%b rd=%b addr=%h wdata=%h required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_data, ddr_wr_req, ddr_rd_req, ddr_addr, ddr_wr_data);
        end
        req_valid[0] = 1'b0;
        step(1);
        repeat (3) step(0);
    endtask

    task automatic test_write;
        int n0 = rsp_log.size();
        push_req(0, 1'b1, 10'd5, 32'hDEADBEEF, 0);
        drain(50);
        n_vec++;
        if (rsp_log.size() != n0 + 1) begin
            n_err++;
            $display("FAIL write_rsp_count got=%0d required=%0d", rsp_log.size() - n0, 1);
        end else if (rsp_log[n0].ch != 0 || rsp_log[n0].err !== 1'b0 || rsp_log[n0].data !== '0 ||
                     rsp_log[n0].cyc - acc_cyc_log[$] != 2) begin
            n_err++;
            $display("FAIL write_rsp got ch=%0d err=%b data=%h lat=%0d required ch=0 err=0 data=0 lat=2",
                     rsp_log[n0].ch, rsp_log[n0].err, rsp_log[n0].data, rsp_log[n0].cyc - acc_cyc_log[$]);
        end
        n_vec++;
        if (dev_mem[5] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_ddr_mem got=%h required=deadbeef", dev_mem[5]);
        end
    endtask

    task automatic test_read;
        logic [DW-1:0] want[2];
        logic [AW-1:0] addr[2];
        want[0] = 32'hDEADBEEF; addr[0] = 10'd5;
        want[1] = 32'hCAFEBABE; addr[1] = 10'd10;
        for (int i = 0; i < 2; i++) begin
            int n0 = rsp_log.size();
            push_req(1, 1'b0, addr[i], '0, 1);
            drain(50);
            n_vec++;
            if (rsp_log.size() != n0 + 1) begin
                n_err++;
                $display("FAIL read_rsp_count addr=%0d got=%0d required=1", addr[i], rsp_log.size() - n0);
            end else if (rsp_log[n0].ch != 1 || rsp_log[n0].err !== 1'b0 || rsp_log[n0].data !== want[i] ||
                         rsp_log[n0].cyc - acc_cyc_log[$] != 3) begin
                n_err++;
                $display("FAIL read_rsp addr=%0d got ch=%0d err=%b data=%h lat=%0d required ch=1 err=0 data=%h lat=3",
                         addr[i], rsp_log[n0].ch, rsp_log[n0].err, rsp_log[n0].data,
                         rsp_log[n0].cyc - acc_cyc_log[$], want[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        int n0;
        int order[4];
        order = '{0, 1, 2, 0};
        push_req(2, 1'b0, 10'd1, '0, 1);   // parks the pointer back at channel 0
        drain(50);
        n0 = grant_log.size();
        push_req(0, 1'b0, 10'd5, '0, 2);
        push_req(0, 1'b0, 10'd10, '0, 1);
        push_req(1, 1'b0, 10'd10, '0, 3);
        push_req(2, 1'b0, 10'd5, '0, 1);
        drain(200);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (grant_log.size() < n0 + 4 || grant_log[n0 + i] != order[i]) begin
                n_err++;
                $display("FAIL rr_order idx=%0d got=%0d required=%0d", i,
                         (grant_log.size() > n0 + i) ? grant_log[n0 + i] : -1, order[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int n0 = rsp_log.size();
        push_req(2, 1'b0, 10'd3, '0, 0);
        drain(60);
        n_vec++;
        if (rsp_log.size() != n0 + 1) begin
            n_err++;
            $display("FAIL timeout_rsp_count got=%0d required=1", rsp_log.size() - n0);
        end else if (rsp_log[n0].ch != 2 || rsp_log[n0].err !== 1'b1 || rsp_log[n0].data !== '0 ||
                     rsp_log[n0].cyc - acc_cyc_log[$] != TO + 2) begin
            n_err++;
            $display("FAIL timeout_rsp got ch=%0d err=%b data=%h lat=%0d required ch=2 err=1 data=0 lat=%0d",
                     rsp_log[n0].ch, rsp_log[n0].err, rsp_log[n0].data, rsp_log[n0].cyc - acc_cyc_log[$], TO + 2);
        end
        // data that shows up after the timeout, and a stray pulse, must both be ignored
        n0 = rsp_log.size();
        push_req(0, 1'b0, 10'd4, '0, TO + 4);
        drain(60);
        repeat (8) step(0);
        stray = 1;
        repeat (4) step(0);
        n_vec++;
        if (rsp_log.size() != n0 + 1 || rsp_log[n0].err !== 1'b1) begin
            n_err++;
            $display("FAIL late_data_ignored got=%0d responses required=1 with err", rsp_log.size() - n0);
        end
    endtask

    task automatic test_terminal_count;
        int lats[2];
        lats = '{TO, TO - 1};
        for (int i = 0; i < 2; i++) begin
            int n0 = rsp_log.size();
            push_req(1, 1'b0, 10'd10, '0, lats[i]);
            drain(60);
            n_vec++;
            if (rsp_log.size() != n0 + 1) begin
                n_err++;
                $display("FAIL terminal_rsp_count lat=%0d got=%0d required=1", lats[i], rsp_log.size() - n0);
            end else if (rsp_log[n0].err !== 1'b0 || rsp_log[n0].data !== 32'hCAFEBABE ||
                         rsp_log[n0].cyc - acc_cyc_log[$] != lats[i] + 2) begin
                n_err++;
                $display("FAIL terminal_rsp lat=%0d got err=%b data=%h lat=%0d required err=0 data=cafebabe lat=%0d",
                         lats[i], rsp_log[n0].err, rsp_log[n0].data, rsp_log[n0].cyc - acc_cyc_log[$], lats[i] + 2);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n0, g0;
        push_req(1, 1'b0, 10'd7, '0, 0);
        n0 = acc_cyc_log.size();
        for (int i = 0; i < 20 && acc_cyc_log.size() == n0; i++) step(0);
        repeat (5) step(0);
        n0 = rsp_log.size();
        step(1);
        repeat (TO + 4) step(0);
        n_vec++;
        if (rsp_log.size() != n0) begin
            n_err++;
            $display("FAIL reset_drop got=%0d responses required=0", rsp_log.size() - n0);
        end
        g0 = grant_log.size();
        push_req(2, 1'b1, 10'd20, 32'h1234, 0);
        push_req(1, 1'b1, 10'd21, 32'h5678, 0);
        push_req(0, 1'b1, 10'd22, 32'h9ABC, 0);
        drain(100);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (grant_log.size() < g0 + 3 || grant_log[g0 + i] != i) begin
                n_err++;
                $display("FAIL reset_ptr idx=%0d got=%0d required=%0d", i,
                         (grant_log.size() > g0 + i) ? grant_log[g0 + i] : -1, i);
            end
        end
    endtask

    task automatic test_random;
        int pushed[NCH];
        int got[NCH];
        int n0 = rsp_log.size();
        for (int i = 0; i < NCH; i++) begin pushed[i] = 0; got[i] = 0; end
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 4; j++) begin
                int ch = $urandom_range(0, NCH - 1);
                int r  = $urandom_range(0, 9);
                int lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 6);
                push_req(ch, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, lat);
                pushed[ch]++;
            end
            repeat ($urandom_range(0, 12)) step(0);
        end
        drain(3000);
        for (int k = n0; k < rsp_log.size(); k++) if (rsp_log[k].ch >= 0) got[rsp_log[k].ch]++;
        for (int i = 0; i < NCH; i++) begin
            n_vec++;
            if (got[i] != pushed[i]) begin
                n_err++;
                $display("FAIL random_count ch=%0d got=%0d required=%0d", i, got[i], pushed[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom;
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[10] = 32'hCAFEBABE;
        dev_mem[10] = 32'hCAFEBABE;
        for (int i = 0; i < NCH; i++) pop_pend[i] = 0;

        test_reset;
        test_write;
        test_read;
        test_round_robin;
        test_timeout;
        test_terminal_count;
        test_reset_mid;
        test_random;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
Multi-channel successor to the single-port memory controller. It accepts read and write requests from NUM_CH masters (CPU, DMA, debug) over valid/ready handshakes and arbitrates between them round-robin. It issues one transaction at a time on the existing single-beat DDR request interface and returns a per-channel response. A read-timeout path turns a silent DDR model or PHY into an error response instead of a hang.

Parameters:
ADDR_WIDTH, 10, word address width on both sides
DATA_WIDTH, 32, data word width
NUM_CH, 3, number of requesting channels (1..8)
RD_TIMEOUT, 16, cycles spent in RD_WAIT without ddr_rd_valid before an error response (>=2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel request accept
req_we  in  NUM_CH  1 = write, 0 = read
req_addr  in  NUM_CH*ADDR_WIDTH  flattened; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_CH*DATA_WIDTH  flattened write data, same packing
rsp_valid  out  NUM_CH  one-cycle response pulse, one-hot
rsp_err  out  1  timeout flag, qualified by rsp_valid
rsp_data  out  DATA_WIDTH  read data, qualified by rsp_valid; 0 for writes and errors
ddr_wr_req  out  1  one-cycle DDR write strobe
ddr_rd_req  out  1  one-cycle DDR read strobe
ddr_addr  out  ADDR_WIDTH  DDR address
ddr_wr_data  out  DATA_WIDTH  DDR write data
ddr_rd_data  in  DATA_WIDTH  DDR read data
ddr_rd_valid  in  1  DDR read data valid

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE; all outputs 0; RR pointer 0; timeout counter 0.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE:
  - The arbiter picks the first asserted req_valid, searching from the RR pointer upward with wrap.
  - req_ready is combinational: high only for the granted channel, and only in IDLE.
  - A transfer occurs on req_valid & req_ready.
  - On that edge: latch channel, we, addr and wdata; set pointer = (grant+1) mod NUM_CH; go to ISSUE.
  - Masters must hold their request fields stable until ready.
- ISSUE: lasts one cycle. ddr_wr_req or ddr_rd_req = 1, with ddr_addr and ddr_wr_data driven from the latched request. Next state: write -> RESP; read -> RD_WAIT with counter cleared.
- RD_WAIT:
  - If ddr_rd_valid is sampled, capture ddr_rd_data and go to RESP with err=0.
  - Otherwise increment the counter. When it reaches RD_TIMEOUT-1, go to RESP with err=1 and data=0.
  - ddr_rd_valid in the same cycle as the terminal count wins: it is a normal response.
- RESP: lasts one cycle. rsp_valid[latched channel]=1 with rsp_err and rsp_data registered. Next state IDLE.
- Latency, with the accept cycle as T:
  - Write: ddr_wr_req at T+1, rsp_valid at T+2.
  - Read: ddr_rd_req at T+1; ddr_rd_valid at cycle k>=T+2 gives rsp_valid at k+1.
  - Earliest next accept is the cycle after RESP. Peak write throughput is one per 3 cycles.
- ddr_rd_valid outside RD_WAIT is ignored; it covers late data after a timeout and stray pulses.
- All ddr_* and rsp_* outputs are 0 whenever not in their active state (ddr_addr and ddr_wr_data included).
- Reset mid-transaction: return to IDLE immediately. The in-flight transaction is dropped with no rsp_valid, and the pointer returns to 0.
- NUM_CH=1: the arbiter degenerates to a pass-through and the pointer stays 0.

Decomposition:
- mem_ctrl_pkg:
  - state enum (IDLE/ISSUE/RD_WAIT/RESP)
  - localparam CH_W = $clog2(NUM_CH) helper
  - RESP_ERR_DATA constant (0)
- Sub-module rr_arbiter: NUM_CH request bits in; one-hot grant and grant index out; pointer register updated on an accept strobe.
- The FSM and datapath live in mem_arb_ctrl.

Test Plan:
1. Reset, then ch0 writes addr 5 data DEADBEEF -> ddr_wr_req for one cycle with addr 5 and DEADBEEF; rsp_valid=001 two cycles after accept, err 0, data 0.
2. ch1 reads addr 5 from a 1-cycle DDR model -> ddr_rd_req at T+1; rsp_valid=010 at T+3 with rsp_data DEADBEEF; a read of preloaded addr 10 returns CAFEBABE.
3. ch0, ch1 and ch2 all hold read requests -> grants in order 0,1,2,0 with exactly one outstanding DDR op; each rsp_valid goes to the matching channel.
4. DDR model never asserts ddr_rd_valid, RD_TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_data 0 after 16 RD_WAIT cycles; a late ddr_rd_valid afterwards produces no response.
5. ddr_rd_valid arrives exactly on the terminal-count cycle -> rsp_err=0 with the correct data.
6. reset asserted for one cycle during RD_WAIT -> no rsp_valid, all outputs 0, the next request is granted to ch0 first.
